// File: rtl/bus_dbg_master_if.sv
// Byte-stream and data-bus signal bundle for the serial debug bus initiator.
// The master modport is the initiator's view; slave is the host/bus side.
interface bus_dbg_master_if;
  logic [7:0]  i_rx_data;
  logic        i_rx_valid;
  logic [7:0]  o_tx_data;
  logic        o_tx_valid;
  logic        i_tx_busy;
  logic        o_bus_req;
  logic        i_bus_gnt;
  logic [31:0] o_addr;
  logic [31:0] o_data_wr;
  logic [3:0]  o_wr;
  logic        o_rd;
  logic [31:0] i_data_rd;

  modport master (
    input  i_rx_data, i_rx_valid, i_tx_busy, i_bus_gnt, i_data_rd,
    output o_tx_data, o_tx_valid, o_bus_req, o_addr, o_data_wr, o_wr, o_rd
  );

  modport slave (
    output i_rx_data, i_rx_valid, i_tx_busy, i_bus_gnt, i_data_rd,
    input  o_tx_data, o_tx_valid, o_bus_req, o_addr, o_data_wr, o_wr, o_rd
  );
endinterface

// File: rtl/bus_dbg_master.sv
// Serial-command bus initiator: host frames 'R'/'W' become single-word data-bus accesses.
// Define BUS_DBG_AUTOINC_EN to add the 'r'/'w' auto-increment commands.
module bus_dbg_master #(
  parameter int         TIMEOUT_CYCLES = 1000000,
  parameter logic [7:0] ACK_BYTE       = 8'h06
) (
  input logic             i_clk,
  input logic             i_rst,
  bus_dbg_master_if.master bus
);

  localparam int TW = $clog2(TIMEOUT_CYCLES) + 1;

  typedef enum logic [2:0] {
    S_IDLE, S_ADDR, S_DATA, S_REQ, S_BUS, S_CAP, S_RESP, S_ACK
  } state_t;

  state_t        state;
  logic [1:0]    byte_cnt;
  logic          is_wr;
  logic [31:0]   addr_asm;
  logic [31:0]   data_asm;
  logic [31:0]   rdata;
  logic [TW-1:0] tmo_cnt;
  logic          tx_wait;
  logic          tmo_hit;

  assign tmo_hit = (tmo_cnt == TW'(TIMEOUT_CYCLES - 1));

  // tx_wait blocks the next byte until the transmitter has shown busy and dropped it again.
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      state         <= S_IDLE;
      byte_cnt      <= 2'd0;
      is_wr         <= 1'b0;
      addr_asm      <= 32'h0;
      data_asm      <= 32'h0;
      rdata         <= 32'h0;
      tmo_cnt       <= '0;
      tx_wait       <= 1'b0;
      bus.o_tx_data <= 8'h0;
      bus.o_tx_valid<= 1'b0;
      bus.o_bus_req <= 1'b0;
      bus.o_addr    <= 32'h0;
      bus.o_data_wr <= 32'h0;
      bus.o_wr      <= 4'h0;
      bus.o_rd      <= 1'b0;
    end else begin
      bus.o_tx_valid <= 1'b0;
      if (bus.i_tx_busy)
        tx_wait <= 1'b0;

      if (bus.i_rx_valid || !((state == S_ADDR) || (state == S_DATA)))
        tmo_cnt <= '0;
      else
        tmo_cnt <= tmo_cnt + 1'b1;

      case (state)
        S_IDLE: begin
          if (bus.i_rx_valid) begin
            case (bus.i_rx_data)
              8'h52: begin is_wr <= 1'b0; state <= S_ADDR; end
              8'h57: begin is_wr <= 1'b1; state <= S_ADDR; end
`ifdef BUS_DBG_AUTOINC_EN
              8'h72: begin
                is_wr         <= 1'b0;
                addr_asm      <= bus.o_addr + 32'd4;
                bus.o_bus_req <= 1'b1;
                state         <= S_REQ;
              end
              8'h77: begin
                is_wr    <= 1'b1;
                addr_asm <= bus.o_addr + 32'd4;
                state    <= S_DATA;
              end
`endif
              default: ;
            endcase
          end
        end

        S_ADDR: begin
          if (bus.i_rx_valid) begin
            addr_asm[{byte_cnt, 3'b000} +: 8] <= bus.i_rx_data;
            byte_cnt <= byte_cnt + 2'd1;
            if (byte_cnt == 2'd3) begin
              state         <= is_wr ? S_DATA : S_REQ;
              bus.o_bus_req <= !is_wr;
            end
          end else if (tmo_hit) begin
            state    <= S_IDLE;
            byte_cnt <= 2'd0;
          end
        end

        S_DATA: begin
          if (bus.i_rx_valid) begin
            data_asm[{byte_cnt, 3'b000} +: 8] <= bus.i_rx_data;
            byte_cnt <= byte_cnt + 2'd1;
            if (byte_cnt == 2'd3) begin
              state         <= S_REQ;
              bus.o_bus_req <= 1'b1;
            end
          end else if (tmo_hit) begin
            state    <= S_IDLE;
            byte_cnt <= 2'd0;
          end
        end

        S_REQ: begin
          if (bus.i_bus_gnt) begin
            bus.o_addr    <= {addr_asm[31:2], 2'b00};
            bus.o_data_wr <= data_asm;
            bus.o_rd      <= !is_wr;
            bus.o_wr      <= is_wr ? 4'hF : 4'h0;
            state         <= S_BUS;
          end
        end

        S_BUS: begin
          bus.o_rd <= 1'b0;
          bus.o_wr <= 4'h0;
          state    <= S_CAP;
        end

        // The responder updates read data on negedge, so it is settled by the end of CAP.
        S_CAP: begin
          if (!is_wr)
            rdata <= bus.i_data_rd;
          bus.o_bus_req <= 1'b0;
          state         <= is_wr ? S_ACK : S_RESP;
        end

        S_RESP: begin
          if (!bus.i_tx_busy && !tx_wait) begin
            bus.o_tx_data  <= rdata[{byte_cnt, 3'b000} +: 8];
            bus.o_tx_valid <= 1'b1;
            tx_wait        <= 1'b1;
            byte_cnt       <= byte_cnt + 2'd1;
            if (byte_cnt == 2'd3)
              state <= S_IDLE;
          end
        end

        S_ACK: begin
          if (!bus.i_tx_busy && !tx_wait) begin
            bus.o_tx_data  <= ACK_BYTE;
            bus.o_tx_valid <= 1'b1;
            tx_wait        <= 1'b1;
            state          <= S_IDLE;
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bus_dbg_master.sv
// Scoreboard bench for bus_dbg_master: a frame-level model predicts bus accesses and tx bytes,
// independent monitors pop and compare them as the DUT presents strobes and tx pulses.
module tb_bus_dbg_master;

  localparam int TMO = 100;

  typedef struct {
    logic        is_wr;
    logic [31:0] addr;
    logic [31:0] data;
  } acc_t;

  logic CLK_100MHz = 1'b0;
  logic rst = 1'b0;
  int   check_count = 0;
  int   fail_count = 0;
  int   gnt_mode = 0;

  acc_t        exp_acc_q[$];
  logic [7:0]  exp_tx_q[$];
  logic [31:0] model_mem[logic [31:0]];
  logic [31:0] resp_mem[logic [31:0]];
  logic [31:0] model_last = 32'h0;

  bus_dbg_master_if dbg_if();

  bus_dbg_master #(.TIMEOUT_CYCLES(TMO), .ACK_BYTE(8'h06)) dut (
    .i_clk(CLK_100MHz),
    .i_rst(rst),
    .bus(dbg_if)
  );

  always #5 CLK_100MHz = ~CLK_100MHz;

  task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
    check_count++;
    if (actual !== expected) begin
      fail_count++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(posedge CLK_100MHz); #1;
    dbg_if.i_rx_data  = b;
    dbg_if.i_rx_valid = 1'b1;
    @(posedge CLK_100MHz); #1;
    dbg_if.i_rx_valid = 1'b0;
    repeat ($urandom_range(0, 3)) @(posedge CLK_100MHz);
  endtask

  // Frame-level reference: decide what the frame should do, queue the expectations, then send it.
  task automatic apply_stimulus(input logic [7:0] cmd, input logic [31:0] addr, input logic [31:0] data);
    logic [31:0] a, rd;
    logic is_rd, is_wr, autoinc;
    acc_t e;
    is_rd   = (cmd == 8'h52);
    is_wr   = (cmd == 8'h57);
    autoinc = 1'b0;
`ifdef BUS_DBG_AUTOINC_EN
    if (cmd == 8'h72) begin is_rd = 1'b1; autoinc = 1'b1; end
    if (cmd == 8'h77) begin is_wr = 1'b1; autoinc = 1'b1; end
`endif
    a = autoinc ? model_last + 32'd4 : (addr & 32'hFFFF_FFFC);
    if (is_wr) begin
      model_mem[a] = data;
      e.is_wr = 1'b1; e.addr = a; e.data = data;
      exp_acc_q.push_back(e);
      exp_tx_q.push_back(8'h06);
      model_last = a;
    end else if (is_rd) begin
      rd = model_mem.exists(a) ? model_mem[a] : 32'h0;
      e.is_wr = 1'b0; e.addr = a; e.data = rd;
      exp_acc_q.push_back(e);
      for (int i = 0; i < 4; i++) exp_tx_q.push_back(rd[8*i +: 8]);
      model_last = a;
    end
    send_byte(cmd);
    if ((cmd == 8'h52) || (cmd == 8'h57))
      for (int i = 0; i < 4; i++) send_byte(addr[8*i +: 8]);
    if ((cmd == 8'h57) || (cmd == 8'h77))
      for (int i = 0; i < 4; i++) send_byte(data[8*i +: 8]);
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while ((exp_acc_q.size() != 0 || exp_tx_q.size() != 0) && n < 3000) begin
      @(posedge CLK_100MHz);
      n++;
    end
    check_output("drain_pending", 32'(exp_acc_q.size() + exp_tx_q.size()), 32'h0);
    repeat (6) @(posedge CLK_100MHz);
  endtask

  // Bus arbiter: grant is sticky once given; mode 0 random delay, 1 withheld, 2 immediate.
  initial begin
    dbg_if.i_bus_gnt = 1'b0;
    forever begin
      @(posedge CLK_100MHz); #1;
      if (!dbg_if.o_bus_req)
        dbg_if.i_bus_gnt = 1'b0;
      else if (!dbg_if.i_bus_gnt)
        case (gnt_mode)
          0: dbg_if.i_bus_gnt = ($urandom_range(0, 2) == 0);
          1: dbg_if.i_bus_gnt = 1'b0;
          default: dbg_if.i_bus_gnt = 1'b1;
        endcase
    end
  end

  // Bus monitor and memory responder.
  initial begin
    logic        strobe, prev_strobe;
    logic [31:0] prev_addr;
    acc_t        e;
    prev_strobe = 1'b0;
    prev_addr   = 32'h0;
    dbg_if.i_data_rd = 32'h0;
    forever begin
      @(negedge CLK_100MHz);
      if (!rst) begin
        prev_strobe = 1'b0;
      end else begin
        strobe = dbg_if.o_rd || (dbg_if.o_wr != 4'h0);
        if (prev_strobe) begin
          check_output("strobe_width", {31'h0, strobe}, 32'h0);
          check_output("addr_hold", dbg_if.o_addr, prev_addr);
        end
        if (strobe) begin
          check_output("strobe_owned", {30'h0, dbg_if.o_bus_req, dbg_if.i_bus_gnt}, 32'h3);
          if (exp_acc_q.size() == 0) begin
            check_output("unexpected_access", dbg_if.o_addr, 32'hFFFF_FFFF);
          end else begin
            e = exp_acc_q.pop_front();
            check_output("acc_kind", {27'h0, dbg_if.o_wr, dbg_if.o_rd},
                         e.is_wr ? 32'h1E : 32'h01);
            check_output("acc_addr", dbg_if.o_addr, e.addr);
            if (e.is_wr) check_output("acc_wdata", dbg_if.o_data_wr, e.data);
          end
          if (dbg_if.o_rd)
            dbg_if.i_data_rd = resp_mem.exists(dbg_if.o_addr) ? resp_mem[dbg_if.o_addr] : 32'h0;
          if (dbg_if.o_wr == 4'hF)
            resp_mem[dbg_if.o_addr] = dbg_if.o_data_wr;
        end
        prev_strobe = strobe;
        prev_addr   = dbg_if.o_addr;
      end
    end
  end

  // Transmitter model and tx monitor.
  initial begin
    logic [7:0] b;
    dbg_if.i_tx_busy = 1'b0;
    forever begin
      @(negedge CLK_100MHz);
      if (rst && dbg_if.o_tx_valid) begin
        check_output("tx_while_busy", {31'h0, dbg_if.i_tx_busy}, 32'h0);
        if (exp_tx_q.size() == 0) begin
          check_output("unexpected_tx", {24'h0, dbg_if.o_tx_data}, 32'hFFFF_FFFF);
        end else begin
          b = exp_tx_q.pop_front();
          check_output("tx_byte", {24'h0, dbg_if.o_tx_data}, {24'h0, b});
        end
        @(posedge CLK_100MHz); #1;
        dbg_if.i_tx_busy = 1'b1;
        repeat ($urandom_range(1, 4)) @(posedge CLK_100MHz);
        #1 dbg_if.i_tx_busy = 1'b0;
      end
    end
  end

  initial begin
    #400000;
    $display("[TB] FAIL watchdog: got timeout, expected $finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [7:0]  cmd;
    logic [31:0] a;
    int          k;
    dbg_if.i_rx_data  = 8'h0;
    dbg_if.i_rx_valid = 1'b0;
    rst = 1'b0;
    repeat (3) @(posedge CLK_100MHz);
    #1;
    check_output("rst_bus_req", {31'h0, dbg_if.o_bus_req}, 32'h0);
    check_output("rst_rd", {31'h0, dbg_if.o_rd}, 32'h0);
    check_output("rst_wr", {28'h0, dbg_if.o_wr}, 32'h0);
    check_output("rst_tx_valid", {31'h0, dbg_if.o_tx_valid}, 32'h0);
    check_output("rst_tx_data", {24'h0, dbg_if.o_tx_data}, 32'h0);
    check_output("rst_addr", dbg_if.o_addr, 32'h0);
    check_output("rst_data_wr", dbg_if.o_data_wr, 32'h0);
    rst = 1'b1;
    repeat (2) @(posedge CLK_100MHz);

    $display("[TB] basic write");
    apply_stimulus(8'h57, 32'h0000_0100, 32'hDEAD_BEEF);
    wait_drain();

    $display("[TB] basic read");
    model_mem[32'h8010] = 32'h1234_5678;
    resp_mem[32'h8010]  = 32'h1234_5678;
    apply_stimulus(8'h52, 32'h0000_8010, 32'h0);
    wait_drain();

    $display("[TB] grant stall");
    gnt_mode = 1;
    apply_stimulus(8'h57, 32'h0000_0040, 32'hA5A5_0F0F);
    repeat (50) @(posedge CLK_100MHz);
    #2;
    check_output("stall_req", {31'h0, dbg_if.o_bus_req}, 32'h1);
    check_output("stall_no_strobe", {27'h0, dbg_if.o_wr, dbg_if.o_rd}, 32'h0);
    @(negedge CLK_100MHz);
    gnt_mode = 2;
    @(posedge CLK_100MHz); #2;
    check_output("stall_gnt", {31'h0, dbg_if.i_bus_gnt}, 32'h1);
    check_output("stall_pre_strobe", {28'h0, dbg_if.o_wr}, 32'h0);
    @(posedge CLK_100MHz); #2;
    check_output("stall_strobe", {28'h0, dbg_if.o_wr}, 32'hF);
    gnt_mode = 0;
    wait_drain();

    $display("[TB] frame timeout");
    send_byte(8'h52);
    send_byte(8'h10);
    repeat (TMO + 20) @(posedge CLK_100MHz);
    apply_stimulus(8'h52, 32'h0000_0000, 32'h0);
    wait_drain();

    $display("[TB] unknown command and unaligned address");
    apply_stimulus(8'h41, 32'h0, 32'h0);
    apply_stimulus(8'h52, 32'h0000_0003, 32'h0);
    wait_drain();

    $display("[TB] auto-increment commands");
    apply_stimulus(8'h57, 32'h0000_0020, 32'h1111_2222);
    apply_stimulus(8'h77, 32'h0, 32'h0000_0001);
    wait_drain();
`ifdef BUS_DBG_AUTOINC_EN
    apply_stimulus(8'h52, 32'h0000_0020, 32'h0);
    apply_stimulus(8'h72, 32'h0, 32'h0);
    wait_drain();
`endif

    $display("[TB] reset during bus request");
    gnt_mode = 1;
    send_byte(8'h57);
    for (int i = 0; i < 8; i++) send_byte(8'h3C);
    repeat (5) @(posedge CLK_100MHz);
    #2;
    check_output("midrst_req_before", {31'h0, dbg_if.o_bus_req}, 32'h1);
    rst = 1'b0;
    @(posedge CLK_100MHz); #2;
    check_output("midrst_req_after", {31'h0, dbg_if.o_bus_req}, 32'h0);
    check_output("midrst_no_write", {28'h0, dbg_if.o_wr}, 32'h0);
    rst = 1'b1;
    model_last = 32'h0;
    gnt_mode = 0;
    repeat (4) @(posedge CLK_100MHz);
    apply_stimulus(8'h52, 32'h0000_3C3C, 32'h0);
    wait_drain();

    $display("[TB] randomized frames");
    for (int n = 0; n < 30; n++) begin
      k = $urandom_range(0, 9);
      a = 32'h0000_1000 + 32'($urandom_range(0, 15) * 4) + 32'($urandom_range(0, 3));
      if (k == 0) begin
        cmd = 8'($urandom_range(0, 255));
        if (cmd == 8'h52 || cmd == 8'h57 || cmd == 8'h72 || cmd == 8'h77) cmd = 8'h41;
      end else if (k < 5) begin
        cmd = 8'h52;
      end else begin
        cmd = 8'h57;
      end
`ifdef BUS_DBG_AUTOINC_EN
      if (k != 0 && $urandom_range(0, 2) == 0) cmd = cmd | 8'h20;
`endif
      apply_stimulus(cmd, a, $urandom);
      wait_drain();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", check_count, fail_count);
    $finish;
  end

endmodule

// File: doc/bus_dbg_master.md
# bus_dbg_master

Serial-command bus initiator that lets a host read and write 32-bit words on the CPU data bus through a byte stream, for loading RAM and poking peripherals without the CPU. It sits between the UART byte layer and the data-side memory/IO bus. It requests the bus, waits for a grant, then issues single-word accesses using the same address, data, byte-strobe and read-strobe signalling as the CPU data port.

## Interface
- TIMEOUT_CYCLES, 1000000: idle cycles allowed between bytes of one frame before the frame is discarded.
- ACK_BYTE, 8'h06: byte returned after a completed write.

- i_clk  in  1  single clock; all logic on posedge.
- i_rst  in  1  synchronous, active-low reset.
- i_rx_data  in  8  received byte.
- i_rx_valid  in  1  one-cycle strobe; i_rx_data valid.
- o_tx_data  out  8  byte to transmit.
- o_tx_valid  out  1  one-cycle strobe; byte accepted only when i_tx_busy=0.
- i_tx_busy  in  1  transmitter cannot accept a byte.
- o_bus_req  out  1  request ownership of the data bus.
- i_bus_gnt  in  1  bus granted; CPU data port is muxed out.
- o_addr  out  32  bus address (word aligned, [1:0]=0).
- o_data_wr  out  32  write data.
- o_wr  out  4  byte write strobes (4'hF or 4'h0).
- o_rd  out  1  read strobe.
- i_data_rd  in  32  read data.

## Operation
- Frame layout: 1 command byte, 4 address bytes LSB first, then 4 data bytes LSB first (write only).
  - 'R' (8'h52): read word.
  - 'W' (8'h57): write word.
- Any other command byte is discarded; FSM stays IDLE. Address bits [1:0] are forced to 0.
- States:
  - IDLE: on 'R'/'W' latch cmd -> ADDR.
  - ADDR: collect 4 bytes -> DATA (W) or REQ (R).
  - DATA: collect 4 bytes -> REQ.
  - REQ: o_bus_req=1; wait for i_bus_gnt=1 -> BUS.
  - BUS: one cycle with o_rd=1 (R) or o_wr=4'hF (W), o_addr/o_data_wr driven -> CAP.
  - CAP: R latches i_data_rd; drop o_bus_req -> RESP (R) or ACK (W).
  - RESP: send 4 bytes LSB first, one per accepted tx slot -> IDLE.
  - ACK: send ACK_BYTE -> IDLE.
- Bytes arriving in REQ/BUS/CAP/RESP/ACK are dropped; the host waits for the response.
- Byte counter is 2 bits and wraps 3->0 on leaving ADDR/DATA/RESP.
- Timeout: a counter clears on every i_rx_valid. In ADDR/DATA, reaching TIMEOUT_CYCLES-1 discards the partial frame -> IDLE. No timeout applies in other states.

## Timing
- Reset values: o_bus_req=0, o_rd=0, o_wr=4'h0, o_tx_valid=0, o_tx_data=0, o_addr=0, o_data_wr=0; FSM=IDLE, counters=0.
- Reset mid-access drops the bus request on the next edge with no partial write. A write strobe already issued in BUS is not undone.
- o_rd and o_wr are asserted for exactly one cycle, only while o_bus_req=1 and i_bus_gnt=1.
- o_addr and o_data_wr are stable from BUS through CAP.
- Read data is sampled on the posedge ending CAP, one cycle after the BUS cycle, because the responder updates on negedge.
- Grant to bus strobe: 1 cycle. Grant withdrawn while in REQ: keep waiting.
- Tx: o_tx_valid pulses for 1 cycle only when i_tx_busy=0. The next byte waits until i_tx_busy has risen and returned to 0.
- Simultaneous i_rx_valid and timeout expiry: the byte wins and the counter clears.

## Configuration
- BUS_DBG_AUTOINC_EN:
  - Defined: adds commands 'r' (8'h72) and 'w' (8'h77). These skip the address bytes and use the last address +4 (32-bit wrap 32'hFFFFFFFC->0). 'R'/'W' still load the address explicitly. The internal address register updates after every completed access.
  - Undefined: 'r'/'w' are treated as unknown commands and ignored.

## Test plan
- Write: rx 57 00 01 00 00 EF BE AD DE -> one cycle o_wr=F, o_addr=00000100, o_data_wr=DEADBEEF; then tx 06.
- Read: bench memory holds 12345678 @0x8010; rx 52 10 80 00 00 -> o_rd pulse, tx 78 56 34 12 in order.
- Grant stall: hold i_bus_gnt=0 for 50 cycles after the frame -> o_bus_req=1, no strobe; strobe occurs 1 cycle after grant.
- Timeout: TIMEOUT_CYCLES=100; rx 52 10 then silence 100 cycles, then 52 00 00 00 00 -> only a read of 0x00000000.
- Unaligned/unknown: rx 41, then 52 03 00 00 00 -> 41 ignored; read at 0x00000000.
- With BUS_DBG_AUTOINC_EN: rx W-frame to 0x20, then 77 01 00 00 00 -> second write at 0x24 with data 00000001.
